// File: rtl/btn_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_debouncer_pkg
// Description : Shared Simon constants: debouncer FSM encoding, debounce
//               default and button indices used by the LED/tone mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_debouncer_pkg;

    localparam int c_debounce_cycles_default = 500000;
    localparam int c_num_btns                = 4;

    localparam logic [1:0] c_st_idle         = 2'd0;
    localparam logic [1:0] c_st_press_wait   = 2'd1;
    localparam logic [1:0] c_st_held         = 2'd2;
    localparam logic [1:0] c_st_release_wait = 2'd3;

    // Button indices shared with the LED and tone lookup tables
    localparam logic [1:0] c_btn_green  = 2'd0;
    localparam logic [1:0] c_btn_red    = 2'd1;
    localparam logic [1:0] c_btn_yellow = 2'd2;
    localparam logic [1:0] c_btn_blue   = 2'd3;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] onehot_index4(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a vector of independent async bits.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Bits are synchronized individually; no cross-bit coherency is implied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : btn_debouncer
// Description : Accepts a single debounced push-button press/release and
//               reports the button index with registered level and strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_default
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btns,
    output logic [1:0] num,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse
);

    localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [3:0]         w_s;
    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_cand;
    logic [1:0]         r_num;
    logic               r_pressed;
    logic               r_press_pulse;
    logic               r_release_pulse;

    sync_2ff #(
        .WIDTH (c_num_btns)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (btns),
        .o_q (w_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= c_st_idle;
            r_cnt           <= '0;
            r_cand          <= 2'd0;
            r_num           <= 2'd0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (is_onehot4(w_s)) begin
                        r_cand  <= onehot_index4(w_s);
                        r_cnt   <= c_cnt_one;
                        r_state <= c_st_press_wait;
                    end
                end
                c_st_press_wait: begin
                    if (w_s == onehot4(r_cand)) begin
                        if (r_cnt == c_cnt_max) begin
                            r_state       <= c_st_held;
                            r_pressed     <= 1'b1;
                            r_num         <= r_cand;
                            r_press_pulse <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                // Only the accepted button matters while held; others are ignored
                c_st_held: begin
                    if (!w_s[r_cand]) begin
                        r_cnt   <= c_cnt_one;
                        r_state <= c_st_release_wait;
                    end
                end
                c_st_release_wait: begin
                    if (!w_s[r_cand]) begin
                        if (r_cnt == c_cnt_max) begin
                            r_state         <= c_st_idle;
                            r_pressed       <= 1'b0;
                            r_release_pulse <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end else begin
                        r_state <= c_st_held;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign num           = r_num;
    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;

endmodule
`default_nettype wire

// File: tb/tb_btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_debouncer
// Description : Scoreboard bench for btn_debouncer with DEBOUNCE_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debouncer;

    localparam int c_lat = 5;  // edges from first sampling edge to output edge, minus one

    typedef struct {
        bit         is_press;
        logic [1:0] num;
        int         cyc;
    } evt_t;

    logic       clk;
    logic       reset;
    logic [3:0] btns;
    logic [1:0] num;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;

    int   cyc;
    int   checks;
    int   failures;
    evt_t exp_q[$];
    logic r_prev_press;
    logic r_prev_release;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btns          (btns),
        .num           (num),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply(input logic [3:0] v, output int e);
        @(negedge clk);
        btns = v;
        e    = cyc + 1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input bit is_press, input logic [1:0] n, input int at);
        evt_t ev;
        ev.is_press = is_press;
        ev.num      = n;
        ev.cyc      = at;
        exp_q.push_back(ev);
    endtask

    // Monitor: every strobe is matched against the oldest expected event
    always @(negedge clk) begin
        evt_t ev;
        if (press_pulse && release_pulse) chk("pulses_overlap", 32'd1, 32'd0);
        if (press_pulse && r_prev_press) chk("press_pulse_width", 32'd2, 32'd1);
        if (release_pulse && r_prev_release) chk("release_pulse_width", 32'd2, 32'd1);
        if (press_pulse || release_pulse) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {31'd0, press_pulse}, {31'd0, release_pulse ^ 1'b1} ^ 32'd1);
                if (press_pulse && release_pulse) chk("unexpected_event_both", 32'd1, 32'd0);
            end else begin
                ev = exp_q.pop_front();
                chk("evt_kind_press", {31'd0, press_pulse}, {31'd0, ev.is_press});
                chk("evt_cycle", cyc, ev.cyc);
                chk("evt_num", {30'd0, num}, {30'd0, ev.num});
                chk("evt_pressed_level", {31'd0, pressed}, {31'd0, ev.is_press});
            end
        end
        r_prev_press   = press_pulse;
        r_prev_release = release_pulse;
    end

    initial begin
        int e;
        checks         = 0;
        failures       = 0;
        r_prev_press   = 1'b0;
        r_prev_release = 1'b0;
        btns           = 4'b0000;
        reset          = 1'b1;
        #1;
        chk("rst_num", {30'd0, num}, 32'd0);
        chk("rst_pressed", {31'd0, pressed}, 32'd0);
        chk("rst_press_pulse", {31'd0, press_pulse}, 32'd0);
        chk("rst_release_pulse", {31'd0, release_pulse}, 32'd0);
        wait_cycles(2);
        reset = 1'b0;
        wait_cycles(2);

        // Scenario 1: clean press of button 2, release later
        apply(4'b0100, e);
        expect_evt(1'b1, 2'd2, e + c_lat);
        wait_cycles(8);
        chk("s1_pressed_held", {31'd0, pressed}, 32'd1);
        chk("s1_num_held", {30'd0, num}, 32'd2);
        wait_cycles(10);
        apply(4'b0000, e);
        expect_evt(1'b0, 2'd2, e + c_lat);
        wait_cycles(8);
        chk("s1_pressed_released", {31'd0, pressed}, 32'd0);
        chk("s1_num_kept", {30'd0, num}, 32'd2);

        // Scenario 2: 2-cycle bounce on button 0 is rejected
        apply(4'b0001, e);
        wait_cycles(1);
        apply(4'b0000, e);
        wait_cycles(8);
        chk("s2_pressed", {31'd0, pressed}, 32'd0);
        chk("s2_state_idle", {30'd0, dut.r_state}, 32'd0);

        // Scenario 3: two buttons together rejected, then single accepted
        apply(4'b0011, e);
        wait_cycles(10);
        chk("s3_multi_rejected", {31'd0, pressed}, 32'd0);
        apply(4'b0010, e);
        expect_evt(1'b1, 2'd1, e + c_lat);
        wait_cycles(8);
        apply(4'b0000, e);
        expect_evt(1'b0, 2'd1, e + c_lat);
        wait_cycles(8);

        // Scenario 4: extra button ignored, short release bounce ignored
        apply(4'b1000, e);
        expect_evt(1'b1, 2'd3, e + c_lat);
        wait_cycles(8);
        apply(4'b1001, e);
        wait_cycles(6);
        chk("s4_num_frozen", {30'd0, num}, 32'd3);
        chk("s4_pressed_extra", {31'd0, pressed}, 32'd1);
        apply(4'b0001, e);
        wait_cycles(1);
        apply(4'b1001, e);
        wait_cycles(8);
        chk("s4_pressed_bounce", {31'd0, pressed}, 32'd1);
        chk("s4_num_bounce", {30'd0, num}, 32'd3);
        apply(4'b0000, e);
        expect_evt(1'b0, 2'd3, e + c_lat);
        wait_cycles(8);

        // Scenario 5: async reset mid-HELD, button still held afterwards
        apply(4'b0100, e);
        expect_evt(1'b1, 2'd2, e + c_lat);
        wait_cycles(8);
        chk("s5_pressed_before_rst", {31'd0, pressed}, 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("s5_rst_pressed", {31'd0, pressed}, 32'd0);
        chk("s5_rst_num", {30'd0, num}, 32'd0);
        chk("s5_rst_press_pulse", {31'd0, press_pulse}, 32'd0);
        chk("s5_rst_release_pulse", {31'd0, release_pulse}, 32'd0);
        wait_cycles(2);
        reset = 1'b0;
        e     = cyc + 1;
        expect_evt(1'b1, 2'd2, e + c_lat);
        wait_cycles(8);
        apply(4'b0000, e);
        expect_evt(1'b0, 2'd2, e + c_lat);
        wait_cycles(8);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
